// File: rtl/tour_move_eval.sv
// tour_move_eval: evaluates an adjacent-swap or 2-opt move over four tour points.
// Two distance lanes (old path on A, new path on B) share the schedule; each lane
// is a 2-stage pipeline feeding its own cost accumulator.
module tour_move_eval #(
  parameter int COORD_W = 8,
  parameter int METRIC  = 0,
  parameter int SUM_W   = 2*COORD_W+3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              mode,
  input  logic [4*COORD_W-1:0]    px,
  input  logic [4*COORD_W-1:0]    py,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SUM_W-1:0]        cost_old,
  output logic [SUM_W-1:0]        cost_new,
  output logic signed [SUM_W:0]   delta,
  output logic                    improve,
  output logic                    err
);

  localparam int SEG_W = 2*COORD_W+1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [1:0]             r_cnt;
  logic                   r_twoopt;
  logic                   r_err;
  logic [4*COORD_W-1:0]   r_px;
  logic [4*COORD_W-1:0]   r_py;

  logic                   w_accept_in;
  logic                   w_accept_out;
  logic                   w_last_issue;
  logic                   w_vld_p0;
  logic [1:0]             w_a0, w_a1, w_b0, w_b1;

  logic [COORD_W-1:0]     r_dxa_p1, r_dya_p1, r_dxb_p1, r_dyb_p1;
  logic                   r_vld_p1;
  logic [SEG_W-1:0]       r_sega_p2, r_segb_p2;
  logic                   r_vld_p2;

  logic [SUM_W-1:0]       r_acc_old;
  logic [SUM_W-1:0]       r_acc_new;
  logic signed [SUM_W:0]  w_delta;

  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Segment cost; widened before the multiply so the square sum cannot wrap.
  function automatic logic [SEG_W-1:0] seg_cost(input logic [COORD_W-1:0] dx,
                                                input logic [COORD_W-1:0] dy);
    logic [SEG_W-1:0] ex;
    logic [SEG_W-1:0] ey;
    ex = SEG_W'(dx);
    ey = SEG_W'(dy);
    if (METRIC == 1) return ex + ey;
    else             return ex * ex + ey * ey;
  endfunction

  function automatic logic [COORD_W-1:0] pick(input logic [4*COORD_W-1:0] v,
                                              input logic [1:0] idx);
    return v[idx*COORD_W +: COORD_W];
  endfunction

  assign in_ready     = (r_state == IDLE) && !rst;
  assign out_valid    = (r_state == DONE) && !rst;
  assign w_accept_in  = in_valid && in_ready;
  assign w_accept_out = out_valid && out_ready;
  assign w_last_issue = r_twoopt ? (r_cnt == 2'd1) : (r_cnt == 2'd2);
  assign w_vld_p0     = (r_state == ISSUE);

  // Next-state logic for the move sequencer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_accept_in) w_state_nxt = mode[1] ? DONE : ISSUE;
      ISSUE: if (w_last_issue) w_state_nxt = DRAIN;
      DRAIN: if (r_cnt == 2'd1) w_state_nxt = DONE;
      DONE:  if (w_accept_out) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register plus the per-state cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state)                   r_cnt <= 2'd0;
      else if (r_state == ISSUE || r_state == DRAIN) r_cnt <= r_cnt + 2'd1;
    end
  end

  // Capture the move on accept; later input changes are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept_in) begin
      r_px     <= px;
      r_py     <= py;
      r_twoopt <= mode[0];
      r_err    <= mode[1];
    end else if (w_accept_out) begin
      r_err <= 1'b0;
    end
  end

  // Segment schedule: lane A walks the current path, lane B the moved path
  always_comb begin
    w_a0 = 2'd0; w_a1 = 2'd1; w_b0 = 2'd0; w_b1 = 2'd2;
    case ({r_twoopt, r_cnt})
      3'b0_00: begin w_a0 = 2'd0; w_a1 = 2'd1; w_b0 = 2'd0; w_b1 = 2'd2; end
      3'b0_01: begin w_a0 = 2'd1; w_a1 = 2'd2; w_b0 = 2'd2; w_b1 = 2'd1; end
      3'b0_10: begin w_a0 = 2'd2; w_a1 = 2'd3; w_b0 = 2'd1; w_b1 = 2'd3; end
      3'b1_00: begin w_a0 = 2'd0; w_a1 = 2'd1; w_b0 = 2'd0; w_b1 = 2'd2; end
      3'b1_01: begin w_a0 = 2'd2; w_a1 = 2'd3; w_b0 = 2'd1; w_b1 = 2'd3; end
      default: ;
    endcase
  end

  // p0 -> p1: absolute coordinate differences for both lanes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_dxa_p1 <= '0; r_dya_p1 <= '0; r_dxb_p1 <= '0; r_dyb_p1 <= '0;
    end else begin
      r_vld_p1 <= w_vld_p0;
      r_dxa_p1 <= abs_diff(pick(r_px, w_a0), pick(r_px, w_a1));
      r_dya_p1 <= abs_diff(pick(r_py, w_a0), pick(r_py, w_a1));
      r_dxb_p1 <= abs_diff(pick(r_px, w_b0), pick(r_px, w_b1));
      r_dyb_p1 <= abs_diff(pick(r_py, w_b0), pick(r_py, w_b1));
    end
  end

  // p1 -> p2: metric combine into a segment cost
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2  <= 1'b0;
      r_sega_p2 <= '0;
      r_segb_p2 <= '0;
    end else begin
      r_vld_p2  <= r_vld_p1;
      r_sega_p2 <= seg_cost(r_dxa_p1, r_dya_p1);
      r_segb_p2 <= seg_cost(r_dxb_p1, r_dyb_p1);
    end
  end

  // p2 -> accumulators; cleared on reset and on every result accept
  always_ff @(posedge clk) begin
    if (rst || w_accept_out) begin
      r_acc_old <= '0;
      r_acc_new <= '0;
    end else if (r_vld_p2) begin
      r_acc_old <= r_acc_old + SUM_W'(r_sega_p2);
      r_acc_new <= r_acc_new + SUM_W'(r_segb_p2);
    end
  end

  // Result presentation, forced to zero whenever no result is being offered
  always_comb begin
    cost_old = out_valid ? r_acc_old : '0;
    cost_new = out_valid ? r_acc_new : '0;
    w_delta  = $signed({1'b0, cost_old}) - $signed({1'b0, cost_new});
    delta    = w_delta;
    improve  = out_valid && !w_delta[SUM_W] && (w_delta != '0);
    err      = out_valid && r_err;
  end

endmodule
